// File: rtl/i2s_tx_frame_scheduler_if.sv
// Sample-in / slot-out bundle of the I2S transmit frame scheduler.
// master: upstream DSP chain plus serializer side (drives enable and samples).
// slave: the scheduler itself.
interface i2s_tx_frame_scheduler_if #(
  parameter int unsigned DATA_W = 24,
  parameter int unsigned CNT_W  = 16
);
  logic              enable;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_left;
  logic [DATA_W-1:0] in_right;
  logic              lrclk_out;
  logic [DATA_W-1:0] tx_data;
  logic              frame_start;
  logic              underrun;
  logic [CNT_W-1:0]  underrun_count;

  modport master (
    output enable, in_valid, in_left, in_right,
    input  in_ready, lrclk_out, tx_data, frame_start, underrun, underrun_count
  );

  modport slave (
    input  enable, in_valid, in_left, in_right,
    output in_ready, lrclk_out, tx_data, frame_start, underrun, underrun_count
  );
endinterface

// File: rtl/i2s_tx_frame_scheduler.sv
// I2S transmit frame scheduler.
// It divides sclk into left and right slots and buffers stereo pairs in two
// stages, staging and active. It then presents one stable word per slot to
// the serializer.
// Optional build macro I2S_TX_UNDERRUN_HOLD_EN: on an underrun the previous pair
// repeats. When the macro is undefined the underrun frame is silent (zero).
// A pair is only accepted in RUN. A cold start from an empty staging register
// therefore always underruns on its first frame.
module i2s_tx_frame_scheduler #(
  parameter int unsigned SLOT_BITS = 32,
  parameter int unsigned DATA_W    = 24,
  parameter int unsigned CNT_W     = 16
) (
  input  logic                    sclk,
  input  logic                    rst,
  i2s_tx_frame_scheduler_if.slave bus
);

  localparam int unsigned      SC_W      = (SLOT_BITS > 1) ? $clog2(SLOT_BITS) : 1;
  localparam logic [SC_W-1:0]  SLOT_LAST = SC_W'(SLOT_BITS - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_STOP = 2'd2
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [SC_W-1:0]   r_slot_cnt, w_slot_cnt_nxt;
  logic              r_lrclk, w_lrclk_nxt;
  logic [DATA_W-1:0] r_tx_data, w_tx_data_nxt;
  logic              r_frame_start, w_frame_start_nxt;
  logic              r_underrun, w_underrun_nxt;
  logic [CNT_W-1:0]  r_underrun_cnt, w_underrun_cnt_nxt;
  logic [DATA_W-1:0] r_stg_left, r_stg_right, w_stg_left_nxt, w_stg_right_nxt;
  logic              r_stg_full, w_stg_full_nxt;
  logic [DATA_W-1:0] r_act_left, r_act_right, w_act_left_nxt, w_act_right_nxt;

  logic w_end_right;
  logic w_load_now;
  logic w_in_ready;
  logic w_accept;

  // Next-state, buffer handoff and slot timing.
  always_comb begin
    w_state_nxt        = r_state;
    w_slot_cnt_nxt     = r_slot_cnt;
    w_lrclk_nxt        = r_lrclk;
    w_tx_data_nxt      = r_tx_data;
    w_frame_start_nxt  = 1'b0;
    w_underrun_nxt     = 1'b0;
    w_underrun_cnt_nxt = r_underrun_cnt;
    w_stg_left_nxt     = r_stg_left;
    w_stg_right_nxt    = r_stg_right;
    w_stg_full_nxt     = r_stg_full;
    w_act_left_nxt     = r_act_left;
    w_act_right_nxt    = r_act_right;

    w_end_right = (r_state != ST_IDLE) && r_lrclk && (r_slot_cnt == SLOT_LAST);

    // A frame that ends as enable drops goes straight to IDLE.
    case (r_state)
      ST_IDLE: if (bus.enable) w_state_nxt = ST_RUN;
      ST_RUN,
      ST_STOP: begin
        if (bus.enable)       w_state_nxt = ST_RUN;
        else if (w_end_right) w_state_nxt = ST_IDLE;
        else                  w_state_nxt = ST_STOP;
      end
      default: w_state_nxt = ST_IDLE;
    endcase

    w_load_now = (w_state_nxt == ST_RUN) && ((r_state == ST_IDLE) || w_end_right);
    w_in_ready = !rst && (r_state == ST_RUN) && (!r_stg_full || w_load_now);
    w_accept   = bus.in_valid && w_in_ready;

    // Staging hands its pair to active; an empty staging register is an underrun.
    if (w_load_now) begin
      w_frame_start_nxt = 1'b1;
      if (r_stg_full) begin
        w_act_left_nxt  = r_stg_left;
        w_act_right_nxt = r_stg_right;
        w_stg_full_nxt  = 1'b0;
        w_stg_left_nxt  = '0;
        w_stg_right_nxt = '0;
      end else begin
`ifdef I2S_TX_UNDERRUN_HOLD_EN
        w_act_left_nxt  = r_act_left;
        w_act_right_nxt = r_act_right;
`else
        w_act_left_nxt  = '0;
        w_act_right_nxt = '0;
`endif
        w_underrun_nxt = 1'b1;
        if (r_underrun_cnt != CNT_MAX) w_underrun_cnt_nxt = r_underrun_cnt + CNT_W'(1);
      end
    end

    // A same-cycle accept refills the staging register that was just emptied.
    if (w_accept) begin
      w_stg_left_nxt  = bus.in_left;
      w_stg_right_nxt = bus.in_right;
      w_stg_full_nxt  = 1'b1;
    end

    // Slot counter, word select and per-slot data word.
    if (w_state_nxt == ST_IDLE) begin
      w_slot_cnt_nxt = '0;
      w_lrclk_nxt    = 1'b0;
      w_tx_data_nxt  = '0;
    end else if (w_load_now) begin
      w_slot_cnt_nxt = '0;
      w_lrclk_nxt    = 1'b0;
      w_tx_data_nxt  = w_act_left_nxt;
    end else if (r_slot_cnt == SLOT_LAST) begin
      // Every other slot wrap is a new left slot, so only left -> right is left here.
      w_slot_cnt_nxt = '0;
      w_lrclk_nxt    = 1'b1;
      w_tx_data_nxt  = r_act_right;
    end else begin
      w_slot_cnt_nxt = r_slot_cnt + SC_W'(1);
    end
  end

  // FSM state register.
  always_ff @(posedge sclk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Datapath and output registers.
  always_ff @(posedge sclk) begin
    if (rst) begin
      r_slot_cnt     <= '0;
      r_lrclk        <= 1'b0;
      r_tx_data      <= '0;
      r_frame_start  <= 1'b0;
      r_underrun     <= 1'b0;
      r_underrun_cnt <= '0;
      r_stg_left     <= '0;
      r_stg_right    <= '0;
      r_stg_full     <= 1'b0;
      r_act_left     <= '0;
      r_act_right    <= '0;
    end else begin
      r_slot_cnt     <= w_slot_cnt_nxt;
      r_lrclk        <= w_lrclk_nxt;
      r_tx_data      <= w_tx_data_nxt;
      r_frame_start  <= w_frame_start_nxt;
      r_underrun     <= w_underrun_nxt;
      r_underrun_cnt <= w_underrun_cnt_nxt;
      r_stg_left     <= w_stg_left_nxt;
      r_stg_right    <= w_stg_right_nxt;
      r_stg_full     <= w_stg_full_nxt;
      r_act_left     <= w_act_left_nxt;
      r_act_right    <= w_act_right_nxt;
    end
  end

  assign bus.in_ready       = w_in_ready;
  assign bus.lrclk_out      = r_lrclk;
  assign bus.tx_data        = r_tx_data;
  assign bus.frame_start    = r_frame_start;
  assign bus.underrun       = r_underrun;
  assign bus.underrun_count = r_underrun_cnt;

endmodule

// File: tb/tb_i2s_tx_frame_scheduler.sv
// Testbench for i2s_tx_frame_scheduler.
// A frame-level reference model is checked on every cycle. A directed vector
// table then walks the start, underrun, staging-refill, stop and reset cases.
// Further runs cover counter saturation, a 100-frame stream and random
// enable/valid traffic.
module tb_i2s_tx_frame_scheduler;

  localparam int unsigned S  = 32;
  localparam int unsigned F  = 2 * S;
  localparam int unsigned DW = 24;
  localparam int unsigned CW = 4;
`ifdef I2S_TX_UNDERRUN_HOLD_EN
  localparam bit HOLD = 1'b1;
`else
  localparam bit HOLD = 1'b0;
`endif

  logic sclk = 1'b0;
  logic rst;

  i2s_tx_frame_scheduler_if #(.DATA_W(DW), .CNT_W(CW)) bus ();

  i2s_tx_frame_scheduler #(.SLOT_BITS(S), .DATA_W(DW), .CNT_W(CW)) dut (
    .sclk (sclk),
    .rst  (rst),
    .bus  (bus)
  );

  always #5 sclk = ~sclk;

  int n_tests = 0;
  int n_fail  = 0;
  int n_acc   = 0;

  typedef struct packed {
    logic [DW-1:0] l;
    logic [DW-1:0] r;
  } pair_t;

  // Reference model: mode 0 idle, 1 run, 2 stop; phase = position inside the 2*S frame.
  int      m_mode  = 0;
  int      m_phase = 0;
  pair_t   m_stg[$];
  pair_t   m_act   = '0;
  int      m_cnt   = 0;
  bit      m_lr    = 1'b0;
  logic [DW-1:0] m_tx = '0;
  bit      m_fs    = 1'b0;
  bit      m_ur    = 1'b0;

  function automatic int m_next_mode(bit en);
    if (en) return 1;
    if (m_mode == 0 || m_phase == int'(F) - 1) return 0;
    return 2;
  endfunction

  function automatic bit m_new_frame(bit en);
    return (m_next_mode(en) == 1) && (m_mode == 0 || m_phase == int'(F) - 1);
  endfunction

  function automatic bit m_ready(bit r, bit en);
    return !r && (m_mode == 1) && (m_stg.size() == 0 || m_new_frame(en));
  endfunction

  function automatic void m_step(bit r, bit en, bit v, pair_t p);
    int nm;
    bit nf, acc;
    if (r) begin
      m_mode = 0; m_phase = 0; m_stg.delete(); m_act = '0; m_cnt = 0;
      m_lr = 1'b0; m_tx = '0; m_fs = 1'b0; m_ur = 1'b0;
      return;
    end
    nm  = m_next_mode(en);
    nf  = m_new_frame(en);
    acc = v && m_ready(1'b0, en);
    m_fs = nf;
    m_ur = 1'b0;
    if (nf) begin
      if (m_stg.size() > 0) m_act = m_stg.pop_front();
      else begin
        if (!HOLD) m_act = '0;
        m_ur = 1'b1;
        if (m_cnt < (1 << CW) - 1) m_cnt++;
      end
    end
    if (acc) m_stg.push_back(p);
    if (nm == 0 || nf) m_phase = 0;
    else               m_phase++;
    m_mode = nm;
    m_lr = (nm != 0) && (m_phase >= int'(S));
    m_tx = (nm == 0) ? '0 : (m_lr ? m_act.r : m_act.l);
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // One sclk cycle. It starts and ends at negedge with inputs already driven.
  task automatic cycle();
    pair_t p;
    p.l = bus.in_left;
    p.r = bus.in_right;
    #1;
    chk("in_ready", 32'(bus.in_ready), 32'(m_ready(rst, bus.enable)));
    if (!rst && bus.in_valid && bus.in_ready) n_acc++;
    m_step(rst, bus.enable, bus.in_valid, p);
    @(posedge sclk);
    #1;
    chk("lrclk", 32'(bus.lrclk_out), 32'(m_lr));
    chk("tx_data", 32'(bus.tx_data), 32'(m_tx));
    chk("frame_start", 32'(bus.frame_start), 32'(m_fs));
    chk("underrun", 32'(bus.underrun), 32'(m_ur));
    chk("underrun_count", 32'(bus.underrun_count), 32'(m_cnt));
    @(negedge sclk);
  endtask

  typedef struct {
    bit            r, en, v;
    logic [DW-1:0] l, rr;
    int            n;
    bit            e_lr;
    logic [DW-1:0] e_tx;
    bit            e_fs, e_ur;
    int            e_cnt;
    bit            e_rdy;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(bit r, bit en, bit v, logic [DW-1:0] l, logic [DW-1:0] rr,
                              int n, bit e_lr, logic [DW-1:0] e_tx, bit e_fs, bit e_ur,
                              int e_cnt, bit e_rdy);
    vec_t t;
    t.r = r; t.en = en; t.v = v; t.l = l; t.rr = rr; t.n = n;
    t.e_lr = e_lr; t.e_tx = e_tx; t.e_fs = e_fs; t.e_ur = e_ur; t.e_cnt = e_cnt; t.e_rdy = e_rdy;
    tbl.push_back(t);
  endfunction

  initial begin
    logic [DW-1:0] z;
    z = '0;
    rst = 1'b1;
    bus.enable = 1'b0; bus.in_valid = 1'b0; bus.in_left = '0; bus.in_right = '0;

    //   rst   en    v     left        right       n   lr    tx                                 fs    ur    cnt rdy
    add(1'b1, 1'b0, 1'b0, z,          z,          3,  1'b0, z,                                 1'b0, 1'b0, 0, 1'b0);
    add(1'b0, 1'b1, 1'b1, 24'h123456, 24'hABCDEF, 1,  1'b0, z,                                 1'b1, 1'b1, 1, 1'b1);
    add(1'b0, 1'b1, 1'b1, 24'h123456, 24'hABCDEF, 1,  1'b0, z,                                 1'b0, 1'b0, 1, 1'b0);
    add(1'b0, 1'b1, 1'b0, z,          z,          62, 1'b1, z,                                 1'b0, 1'b0, 1, 1'b1);
    add(1'b0, 1'b1, 1'b0, z,          z,          1,  1'b0, 24'h123456,                        1'b1, 1'b0, 1, 1'b1);
    add(1'b0, 1'b1, 1'b0, z,          z,          31, 1'b0, 24'h123456,                        1'b0, 1'b0, 1, 1'b1);
    add(1'b0, 1'b1, 1'b0, z,          z,          1,  1'b1, 24'hABCDEF,                        1'b0, 1'b0, 1, 1'b1);
    add(1'b0, 1'b1, 1'b0, z,          z,          32, 1'b0, HOLD ? 24'h123456 : z,             1'b1, 1'b1, 2, 1'b1);
    add(1'b0, 1'b1, 1'b0, z,          z,          32, 1'b1, HOLD ? 24'hABCDEF : z,             1'b0, 1'b0, 2, 1'b1);
    add(1'b0, 1'b1, 1'b1, 24'h111111, 24'h222222, 1,  1'b1, HOLD ? 24'hABCDEF : z,             1'b0, 1'b0, 2, 1'b0);
    add(1'b0, 1'b1, 1'b1, 24'h333333, 24'h444444, 30, 1'b1, HOLD ? 24'hABCDEF : z,             1'b0, 1'b0, 2, 1'b1);
    add(1'b0, 1'b1, 1'b1, 24'h333333, 24'h444444, 1,  1'b0, 24'h111111,                        1'b1, 1'b0, 2, 1'b0);
    add(1'b0, 1'b1, 1'b0, z,          z,          64, 1'b0, 24'h333333,                        1'b1, 1'b0, 2, 1'b1);
    add(1'b0, 1'b1, 1'b0, z,          z,          5,  1'b0, 24'h333333,                        1'b0, 1'b0, 2, 1'b1);
    add(1'b0, 1'b0, 1'b0, z,          z,          1,  1'b0, 24'h333333,                        1'b0, 1'b0, 2, 1'b0);
    add(1'b0, 1'b0, 1'b0, z,          z,          57, 1'b1, 24'h444444,                        1'b0, 1'b0, 2, 1'b0);
    add(1'b0, 1'b0, 1'b0, z,          z,          1,  1'b0, z,                                 1'b0, 1'b0, 2, 1'b0);
    add(1'b0, 1'b0, 1'b0, z,          z,          10, 1'b0, z,                                 1'b0, 1'b0, 2, 1'b0);
    add(1'b0, 1'b1, 1'b1, 24'h555555, 24'h666666, 40, 1'b1, HOLD ? 24'h444444 : z,             1'b0, 1'b0, 3, 1'b0);
    add(1'b1, 1'b1, 1'b1, 24'h555555, 24'h666666, 3,  1'b0, z,                                 1'b0, 1'b0, 0, 1'b0);
    add(1'b0, 1'b0, 1'b0, z,          z,          1,  1'b0, z,                                 1'b0, 1'b0, 0, 1'b0);

    @(negedge sclk);

    // Directed vectors: hold each record's inputs for n cycles, then check.
    for (int i = 0; i < tbl.size(); i++) begin
      rst = tbl[i].r; bus.enable = tbl[i].en; bus.in_valid = tbl[i].v;
      bus.in_left = tbl[i].l; bus.in_right = tbl[i].rr;
      repeat (tbl[i].n) cycle();
      chk($sformatf("vec%0d_lrclk", i), 32'(bus.lrclk_out), 32'(tbl[i].e_lr));
      chk($sformatf("vec%0d_tx", i), 32'(bus.tx_data), 32'(tbl[i].e_tx));
      chk($sformatf("vec%0d_fs", i), 32'(bus.frame_start), 32'(tbl[i].e_fs));
      chk($sformatf("vec%0d_ur", i), 32'(bus.underrun), 32'(tbl[i].e_ur));
      chk($sformatf("vec%0d_cnt", i), 32'(bus.underrun_count), 32'(tbl[i].e_cnt));
      chk($sformatf("vec%0d_rdy", i), 32'(bus.in_ready), 32'(tbl[i].e_rdy));
    end

    // The underrun counter saturates at 2^CW-1 over 20 starved frames.
    rst = 1'b0; bus.enable = 1'b1; bus.in_valid = 1'b0;
    repeat (20 * F) cycle();
    chk("sat_count", 32'(bus.underrun_count), 32'((1 << CW) - 1));

    // Continuous stream: only the cold-start frame underruns, then one pair per frame.
    rst = 1'b1; cycle();
    rst = 1'b0; bus.enable = 1'b1; bus.in_valid = 1'b1;
    repeat (2 * F) begin
      bus.in_left = DW'($urandom); bus.in_right = DW'($urandom);
      cycle();
    end
    chk("stream_warm_count", 32'(bus.underrun_count), 32'd1);
    n_acc = 0;
    repeat (100 * F) begin
      bus.in_left = DW'($urandom); bus.in_right = DW'($urandom);
      cycle();
    end
    chk("stream_accepts", 32'(n_acc), 32'd100);
    chk("stream_count", 32'(bus.underrun_count), 32'd1);

    // Random enable/valid/reset traffic against the model.
    for (int k = 0; k < 8000; k++) begin
      if ($urandom_range(49) == 0) bus.enable = ~bus.enable;
      bus.in_valid = ($urandom_range(2) != 0);
      bus.in_left  = DW'($urandom);
      bus.in_right = DW'($urandom);
      rst = ($urandom_range(999) == 0);
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
